// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin front end for the bridge's single APB master port.
// Optional macro APB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYCLES wait states.
module apb_req_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              req0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [2:0]        Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  input  logic [DATA_W-1:0] Prdata,
  input  logic              Pready
);

  // ERROR is the extra cycle that reports an unmapped grant made at a completion edge
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERROR} state_t;

  state_t            state;
  logic              last;
  logic              owner;
  logic              elig0;
  logic              elig1;
  logic              g_any;
  logic              g_idx;
  logic              g_wr;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic [2:0]        g_sel;
  logic              timeout_hit;
  logic              finish;

  function automatic logic [2:0] decode(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] region;
    region = a >> 26;
    case (region)
      ADDR_W'(32): decode = 3'b001;
      ADDR_W'(33): decode = 3'b010;
      ADDR_W'(34): decode = 3'b100;
      default:     decode = 3'b000;
    endcase
  endfunction

  // A requester whose done is showing this cycle is masked so its held req is not re-granted
  always_comb begin
    elig0 = req0 & ~done0;
    elig1 = req1 & ~done1;
    g_any = 1'b0;
    g_idx = 1'b0;
    if (state == IDLE) begin
      g_any = elig0 | elig1;
      g_idx = (elig0 & elig1) ? ~last : elig1;
    end else begin
      g_idx = ~owner;
      g_any = owner ? req0 : req1;
    end
    g_wr    = g_idx ? wr1 : wr0;
    g_addr  = g_idx ? addr1 : addr0;
    g_wdata = g_idx ? wdata1 : wdata0;
    g_sel   = decode(g_addr);
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !Pready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign timeout_hit = (state == ACCESS) && !Pready && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign finish = (state == ACCESS) && (Pready || timeout_hit);

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state   <= IDLE;
      last    <= 1'b1;
      owner   <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
      Pselx   <= 3'b000;
      Penable <= 1'b0;
      Pwrite  <= 1'b0;
      Paddr   <= '0;
      Pwdata  <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
      case (state)
        IDLE: begin
          if (g_any) begin
            owner <= g_idx;
            if (g_sel != 3'b000) begin
              Pselx   <= g_sel;
              Penable <= 1'b0;
              Paddr   <= g_addr;
              Pwrite  <= g_wr;
              Pwdata  <= g_wdata;
              state   <= SETUP;
            end else begin
              {done1, done0} <= g_idx ? 2'b10 : 2'b01;
              err            <= 1'b1;
              last           <= g_idx;
            end
          end
        end
        SETUP: begin
          Penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (finish) begin
            last           <= owner;
            {done1, done0} <= owner ? 2'b10 : 2'b01;
            err            <= !Pready;
            rdata          <= (Pready && !Pwrite) ? Prdata : '0;
            Penable        <= 1'b0;
            if (g_any) begin
              owner <= g_idx;
              if (g_sel != 3'b000) begin
                Pselx  <= g_sel;
                Paddr  <= g_addr;
                Pwrite <= g_wr;
                Pwdata <= g_wdata;
                state  <= SETUP;
              end else begin
                Pselx <= 3'b000;
                state <= ERROR;
              end
            end else begin
              Pselx <= 3'b000;
              state <= IDLE;
            end
          end
        end
        ERROR: begin
          {done1, done0} <= owner ? 2'b10 : 2'b01;
          err            <= 1'b1;
          last           <= owner;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter: directed transfers, done payloads checked by a monitor.
// Define APB_TIMEOUT_EN for both bench and RTL to exercise the ACCESS abort path.
module tb_apb_req_arbiter;

  logic        Hclk;
  logic        Hresetn;
  logic        req0, wr0, req1, wr1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        done0, done1, err;
  logic [31:0] rdata;
  logic [2:0]  Pselx;
  logic        Penable, Pwrite;
  logic [31:0] Paddr, Pwdata, Prdata;
  logic        Pready;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   wait_n   = 0;
  int   acc_cnt  = 0;

  apb_req_arbiter dut (
    .Hclk(Hclk), .Hresetn(Hresetn),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata(rdata), .err(err),
    .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
    .Prdata(Prdata), .Pready(Pready)
  );

  initial begin
    Hclk = 1'b0;
    forever #5 Hclk = ~Hclk;
  end

  initial forever begin
    @(posedge Hclk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // APB slave: Pready rises after wait_n wait states of the current ACCESS phase
  initial begin
    Pready = 1'b0;
    forever begin
      @(negedge Hclk);
      if (Penable) begin
        Pready = (acc_cnt >= wait_n);
        acc_cnt++;
      end else begin
        Pready  = 1'b0;
        acc_cnt = 0;
      end
    end
  end

  // Monitor: every done pulse is matched against the oldest expected completion
  initial forever begin
    exp_t e;
    @(negedge Hclk);
    if (Hresetn && (done0 || done1)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=%b%b required=none", done1, done0);
      end else begin
        e = exp_q.pop_front();
        check("done_port", 64'({done1, done0}), e.port ? 64'd2 : 64'd1);
        check("done_rdata", 64'(rdata), 64'(e.rdata));
        check("done_err", 64'(err), 64'(e.err));
        $display("done port=%0d rdata=%h err=%b cyc=%0d", e.port, rdata, err, cyc);
      end
    end
  end

  function automatic void push_exp(input logic port, input logic [31:0] rd, input logic er);
    exp_t e;
    e.port  = port;
    e.rdata = rd;
    e.err   = er;
    exp_q.push_back(e);
  endfunction

  task automatic issue(input logic port, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (port) begin
      req1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d;
    end else begin
      req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d;
    end
  endtask

  task automatic wait_done(input logic port, input int budget, input int t0, output int lat);
    bit found;
    found = 0;
    lat   = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge Hclk);
      if ((port && done1) || (!port && done0)) begin
        found = 1;
        lat   = cyc - t0;
        if (port) req1 = 1'b0;
        else      req0 = 1'b0;
        break;
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL wait_done%0d actual=no done required=done within %0d cycles", port, budget);
    end
  endtask

  initial begin
    int t0;
    int lat;
    int ndone;
    int n0;
    int n1;
    int dc[4];

    Hresetn = 1'b0;
    req0 = 0; wr0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0;
    Prdata = '0;
    repeat (3) @(negedge Hclk);
    check("reset_pselx", 64'(Pselx), 64'd0);
    check("reset_penable", 64'(Penable), 64'd0);
    check("reset_done", 64'({done1, done0}), 64'd0);
    check("reset_err_rdata", 64'({err, rdata}), 64'd0);
    check("reset_paddr_pwdata", {Paddr, Pwdata}, 64'd0);
    Hresetn = 1'b1;

    // Single read, zero wait states
    @(posedge Hclk); #1;
    Prdata = 32'hDEAD_BEEF; wait_n = 0;
    push_exp(0, 32'hDEAD_BEEF, 0);
    issue(0, 0, 32'h8000_0010, 32'h0);
    t0 = cyc;
    @(negedge Hclk);
    @(negedge Hclk);
    check("t2_setup", 64'({Pselx, Penable, Pwrite}), 64'({3'b001, 1'b0, 1'b0}));
    check("t2_paddr", 64'(Paddr), 64'h8000_0010);
    @(negedge Hclk);
    check("t2_access", 64'({Pselx, Penable}), 64'({3'b001, 1'b1}));
    wait_done(0, 10, t0, lat);
    check("t2_latency", 64'(lat), 64'd3);
    check("t2_idle_psel", 64'({Pselx, Penable}), 64'd0);
    @(negedge Hclk);
    check("t2_paddr_hold", 64'(Paddr), 64'h8000_0010);

    // Write with three wait states
    @(posedge Hclk); #1;
    Prdata = 32'h5555_AAAA; wait_n = 3;
    push_exp(1, 32'h0, 0);
    issue(1, 1, 32'h8400_0004, 32'h1234_5678);
    t0 = cyc;
    @(negedge Hclk);
    @(negedge Hclk);
    check("t3_setup", 64'({Pselx, Penable, Pwrite}), 64'({3'b010, 1'b0, 1'b1}));
    check("t3_pwdata", 64'(Pwdata), 64'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      @(negedge Hclk);
      check("t3_access_hold", {25'd0, Pselx, Penable, Pwrite, Pwdata}, {25'd0, 3'b010, 1'b1, 1'b1, 32'h1234_5678});
    end
    wait_done(1, 10, t0, lat);
    check("t3_latency", 64'(lat), 64'd6);

    // Both requesting and re-requesting: order 0,1,0,1 with SETUP chained behind each done
    @(posedge Hclk); #1;
    wait_n = 0; Prdata = 32'hCAFE_0001;
    push_exp(0, 32'hCAFE_0001, 0);
    push_exp(1, 32'h0, 0);
    push_exp(0, 32'hCAFE_0001, 0);
    push_exp(1, 32'h0, 0);
    issue(0, 0, 32'h8000_0100, 32'h0);
    issue(1, 1, 32'h8800_0008, 32'hA5A5_0001);
    ndone = 0; n0 = 0; n1 = 0;
    for (int i = 0; i < 40 && ndone < 4; i++) begin
      @(negedge Hclk);
      if (done0 || done1) begin
        dc[ndone] = cyc;
        if (ndone < 3) check("t4_no_bubble", 64'({Pselx != 3'b000, Penable}), 64'd2);
        ndone++;
        if (done0) begin
          n0++;
          if (n0 == 2) req0 = 1'b0;
        end
        if (done1) begin
          n1++;
          if (n1 == 2) req1 = 1'b0;
        end
      end
    end
    check("t4_done_count", 64'(ndone), 64'd4);
    for (int i = 1; i < 4; i++) check("t4_spacing", 64'(dc[i] - dc[i-1]), 64'd2);
    req0 = 1'b0; req1 = 1'b0;

    // Unmapped address
    @(posedge Hclk); #1;
    push_exp(0, 32'h0, 1);
    issue(0, 0, 32'h9000_0000, 32'h0);
    t0 = cyc;
    @(negedge Hclk);
    wait_done(0, 10, t0, lat);
    check("t5_latency", 64'(lat), 64'd1);
    check("t5_no_psel", 64'({Pselx, Penable}), 64'd0);
    @(negedge Hclk);
    check("t5_single_pulse", 64'({done1, done0, Pselx}), 64'd0);

`ifdef APB_TIMEOUT_EN
    // Stuck slave aborts after 16 ACCESS cycles; pending req1 is served next
    @(posedge Hclk); #1;
    wait_n = 1000; Prdata = 32'h1111_2222;
    push_exp(0, 32'h0, 1);
    push_exp(1, 32'h0, 0);
    issue(0, 0, 32'h8000_0040, 32'h0);
    t0 = cyc;
    @(negedge Hclk);
    @(negedge Hclk);
    issue(1, 1, 32'h8400_0010, 32'h0BAD_F00D);
    wait_done(0, 40, t0, lat);
    check("t6_timeout_latency", 64'(lat), 64'd18);
    check("t6_next_setup", 64'({Pselx, Penable}), 64'({3'b010, 1'b0}));
    wait_n = 0;
    wait_done(1, 10, cyc, lat);
`else
    // Long wait without timeout logic completes normally
    @(posedge Hclk); #1;
    wait_n = 20; Prdata = 32'h1111_2222;
    push_exp(0, 32'h1111_2222, 0);
    issue(0, 0, 32'h8000_0040, 32'h0);
    t0 = cyc;
    wait_done(0, 40, t0, lat);
    check("t6_long_wait_latency", 64'(lat), 64'd23);
`endif

    // Asynchronous reset in the middle of ACCESS
    @(posedge Hclk); #1;
    wait_n = 1000;
    issue(0, 0, 32'h8000_0020, 32'h0);
    repeat (3) @(negedge Hclk);
    check("t1_in_access", 64'({Pselx, Penable}), 64'({3'b001, 1'b1}));
    #2 Hresetn = 1'b0;
    #1;
    check("t1_async_psel", 64'({Pselx, Penable}), 64'd0);
    check("t1_async_done", 64'({done1, done0}), 64'd0);
    check("t1_async_paddr", 64'(Paddr), 64'd0);
    req0 = 1'b0;
    @(negedge Hclk);
    Hresetn = 1'b1;
    wait_n = 0;

    // After reset a tie goes to requester 0
    @(posedge Hclk); #1;
    Prdata = 32'h7777_0000;
    push_exp(0, 32'h7777_0000, 0);
    push_exp(1, 32'h0, 0);
    issue(0, 0, 32'h8000_0000, 32'h0);
    issue(1, 1, 32'h8BFF_FFFC, 32'h0000_00FF);
    t0 = cyc;
    wait_done(0, 10, t0, lat);
    check("post_reset_rr_latency", 64'(lat), 64'd3);
    check("post_reset_chain_psel", 64'(Pselx), 64'd4);
    wait_done(1, 10, t0, lat);

    repeat (3) @(negedge Hclk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
